// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side hazard inputs and the control
// outputs (PC write enable plus the four pipeline-register choice codes).
// Modport 'slave' is the hazard unit; modport 'master' is the pipeline/bench.
interface hazard_ctrl_if;
  logic       mem_stall;
  logic       ex_md_start;
  logic       ex_branch_taken;
  logic       id_jump;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       pc_we;
  logic [1:0] ch_ifid;
  logic [1:0] ch_idex;
  logic [1:0] ch_exmem;
  logic [1:0] ch_memwb;

  modport slave (
    input  mem_stall, ex_md_start, ex_branch_taken, id_jump, ex_memread,
           ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output pc_we, ch_ifid, ch_idex, ch_exmem, ch_memwb
  );

  modport master (
    output mem_stall, ex_md_start, ex_branch_taken, id_jump, ex_memread,
           ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  pc_we, ch_ifid, ch_idex, ch_exmem, ch_memwb
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard/control unit for the 5-stage MIPS pipeline.
// Drives the PC write enable and the choice code (FLUSH/LOAD/HOLD) of each
// inter-stage register. Outputs are combinational from state and inputs and
// are consumed at the same clock edge. Handles memory wait stalls, multi-cycle
// mult/div occupancy of EX, taken branches, load-use stalls and jumps.
// Optional build macro HAZ_PERF_EN adds saturating stall/flush perf counters.
module hazard_ctrl #(
  parameter int MD_LAT = 8,   // cycles EX is held by mult/div, 2..255
  parameter int CNT_W  = 32   // perf counter width
) (
  input  logic            clk,
  input  logic            reset,
  hazard_ctrl_if.slave    bus
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] CH_FLUSH = 2'b00;
  localparam logic [1:0] CH_LOAD  = 2'b01;
  localparam logic [1:0] CH_HOLD  = 2'b10;

  // The entry cycle already counts as one occupied cycle, and the release
  // cycle (md_cnt==0) is another, hence the reload of MD_LAT-2.
  localparam logic [7:0] MD_RELOAD = 8'(MD_LAT - 2);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;

  logic       pc_we_d;
  logic [1:0] ch_ifid_d, ch_idex_d, ch_exmem_d, ch_memwb_d;
  logic       load_use;
  logic       flush_evt;

  // Load in EX writes a register the ID instruction reads; $0 never hazards.
  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

  // Prioritised hazard resolution: outputs and FSM next state.
  always_comb begin
    pc_we_d    = 1'b1;
    ch_ifid_d  = CH_LOAD;
    ch_idex_d  = CH_LOAD;
    ch_exmem_d = CH_LOAD;
    ch_memwb_d = CH_LOAD;
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    flush_evt  = 1'b0;
    if (reset) begin
      pc_we_d    = 1'b0;
      ch_ifid_d  = CH_FLUSH;
      ch_idex_d  = CH_FLUSH;
      ch_exmem_d = CH_FLUSH;
      ch_memwb_d = CH_FLUSH;
      state_d    = RUN;
      md_cnt_d   = 8'd0;
    end else if (bus.mem_stall) begin
      // Whole pipe waits on memory; FSM and counter frozen.
      pc_we_d    = 1'b0;
      ch_ifid_d  = CH_HOLD;
      ch_idex_d  = CH_HOLD;
      ch_exmem_d = CH_HOLD;
      ch_memwb_d = CH_HOLD;
    end else if (state_q == MD_WAIT) begin
      if (md_cnt_q != 8'd0) begin
        pc_we_d    = 1'b0;
        ch_ifid_d  = CH_HOLD;
        ch_idex_d  = CH_HOLD;
        ch_exmem_d = CH_FLUSH;
        md_cnt_d   = md_cnt_q - 8'd1;
      end else begin
        // Release cycle: everything loads, ex_md_start is the finishing op.
        state_d = RUN;
      end
    end else if (bus.ex_md_start) begin
      pc_we_d    = 1'b0;
      ch_ifid_d  = CH_HOLD;
      ch_idex_d  = CH_HOLD;
      ch_exmem_d = CH_FLUSH;
      md_cnt_d   = MD_RELOAD;
      state_d    = MD_WAIT;
    end else if (bus.ex_branch_taken) begin
      // Branch squashes both younger instructions, including any jump or
      // load-use consumer sitting in IF/ID.
      ch_ifid_d = CH_FLUSH;
      ch_idex_d = CH_FLUSH;
      flush_evt = 1'b1;
    end else if (load_use) begin
      pc_we_d   = 1'b0;
      ch_ifid_d = CH_HOLD;
      ch_idex_d = CH_FLUSH;
    end else if (bus.id_jump) begin
      ch_ifid_d = CH_FLUSH;
      flush_evt = 1'b1;
    end
  end

  assign bus.pc_we    = pc_we_d;
  assign bus.ch_ifid  = ch_ifid_d;
  assign bus.ch_idex  = ch_idex_d;
  assign bus.ch_exmem = ch_exmem_d;
  assign bus.ch_memwb = ch_memwb_d;

  // FSM state and mult/div occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating perf counters: stalled-PC cycles and branch/jump flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we_d)  stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a
// cycle-level behavioural model (remaining-occupancy count, rule table).
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // Outcome classes of one cycle.
  localparam int K_RST = 0, K_HOLD = 1, K_MD = 2, K_REL = 3, K_BR = 4,
                 K_LU = 5, K_J = 6, K_N = 7;

  logic clk = 1'b0;
  logic reset;
  hazard_ctrl_if bus ();

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int md_left = 0;      // cycles of EX occupancy still to come (model)
  int m_stall = 0;
  int m_flush = 0;
  int obs_stalls = 0;

  // Expected {pc_we, ifid, idex, exmem, memwb} and outcome class for this cycle.
  task automatic model_out(output logic [8:0] e, output int k);
    if (reset) k = K_RST;
    else if (bus.mem_stall) k = K_HOLD;
    else if (md_left > 1) k = K_MD;
    else if (md_left == 1) k = K_REL;
    else if (bus.ex_md_start) k = K_MD;
    else if (bus.ex_branch_taken) k = K_BR;
    else if (bus.ex_memread && bus.ex_rt != 0 &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rt))) k = K_LU;
    else if (bus.id_jump) k = K_J;
    else k = K_N;
    case (k)
      K_RST:   e = 9'b0_00_00_00_00;
      K_HOLD:  e = 9'b0_10_10_10_10;
      K_MD:    e = 9'b0_10_10_00_01;
      K_BR:    e = 9'b1_00_00_01_01;
      K_LU:    e = 9'b0_10_00_01_01;
      K_J:     e = 9'b1_00_01_01_01;
      default: e = 9'b1_01_01_01_01;
    endcase
  endtask

  task automatic model_advance(input int k, input logic [8:0] e);
    if (k == K_RST) begin
      md_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (k == K_MD) md_left = (md_left == 0) ? MD_LAT - 1 : md_left - 1;
      else if (k == K_REL) md_left = 0;
      if (!e[8] && m_stall < CMAX) m_stall++;
      if ((k == K_BR || k == K_J) && m_flush < CMAX) m_flush++;
    end
  endtask

  // One clock cycle: inputs already applied; check outputs, then advance.
  task automatic step(input string tag);
    logic [8:0] e, a;
    int k;
    #1;
    model_out(e, k);
    a = {bus.pc_we, bus.ch_ifid, bus.ch_idex, bus.ch_exmem, bus.ch_memwb};
    if (!bus.pc_we) obs_stalls++;
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, a, e);
    end
`ifdef HAZ_PERF_EN
    checks++;
    assert (stall_cnt === CNT_W'(m_stall) && flush_cnt === CNT_W'(m_flush)) else begin
      errors++;
      $error("FAIL %s_cnt observed=%0d/%0d expected=%0d/%0d",
             tag, stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    @(posedge clk);
    model_advance(k, e);
    #1;
  endtask

  task automatic clear_in();
    bus.mem_stall = 0; bus.ex_md_start = 0; bus.ex_branch_taken = 0;
    bus.id_jump = 0; bus.ex_memread = 0; bus.ex_rt = 0; bus.id_rs = 0;
    bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    clear_in();
    step("reset_a");
    step("reset_b");
    reset = 1'b0;
    // Idle after release
    step("idle_first");
    step("idle_2");
    // Load-use on rs
    bus.ex_memread = 1; bus.ex_rt = 5; bus.id_rs = 5; bus.id_uses_rs = 1;
    step("loaduse_rs");
    // $0 never hazards
    bus.ex_rt = 0; bus.id_rs = 0;
    step("loaduse_r0");
    // rt matches but not read
    clear_in();
    bus.ex_memread = 1; bus.ex_rt = 7; bus.id_rt = 7; bus.id_uses_rt = 0;
    step("rt_unused");
    bus.id_uses_rt = 1;
    step("loaduse_rt");
    // Mult/div occupancy
    clear_in();
    bus.ex_md_start = 1;
    step("md_entry");
    step("md_wait1");
    step("md_wait2");
    step("md_release");
    bus.ex_md_start = 0;
    step("md_after");
    // Branch + jump + load-use together
    bus.ex_branch_taken = 1; bus.id_jump = 1;
    bus.ex_memread = 1; bus.ex_rt = 3; bus.id_rs = 3; bus.id_uses_rs = 1;
    step("br_prio");
    bus.ex_branch_taken = 0;
    step("lu_over_jump");
    bus.ex_memread = 0;
    step("jump");
    // mem_stall during MD_WAIT stretches the stall by exactly 3
    clear_in();
    base = obs_stalls;
    bus.ex_md_start = 1;
    step("md6_entry");
    bus.ex_md_start = 0;
    step("md6_wait");
    bus.mem_stall = 1;
    step("md6_ms1");
    step("md6_ms2");
    step("md6_ms3");
    bus.mem_stall = 0;
    step("md6_wait2");
    step("md6_release");
    checks++;
    assert (obs_stalls - base === MD_LAT - 1 + 3) else begin
      errors++;
      $error("FAIL md_stretch observed=%0d expected=%0d", obs_stalls - base, MD_LAT + 2);
    end
    // Reset mid-MD_WAIT
    bus.ex_md_start = 1;
    step("mdr_entry");
    bus.ex_md_start = 0;
    reset = 1'b1;
    step("mdr_reset");
    reset = 1'b0;
    step("mdr_run");
    step("mdr_run2");
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset               = ($urandom_range(0, 63) == 0);
      bus.mem_stall       = ($urandom_range(0, 5) == 0);
      bus.ex_md_start     = ($urandom_range(0, 7) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
      bus.id_jump         = ($urandom_range(0, 5) == 0);
      bus.ex_memread      = ($urandom_range(0, 2) == 0);
      bus.ex_rt           = 5'($urandom_range(0, 3));
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_uses_rs      = 1'($urandom_range(0, 1));
      bus.id_uses_rt      = 1'($urandom_range(0, 1));
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
